sensor_scan_ctrl: RTL

// - Round-robin scheduler that time-shares one zero-run detector across NCH sensor lines.
// - Each enabled channel gets a DWELL-cycle scan slice.
// - A run of THRESH consecutive 0 samples on the scanned channel raises an alarm.
// - The alarm is handed to the host over a valid/ready handshake, followed by a HOLDOFF pause.
// - Sits between the raw sensor inputs and the host alarm/interrupt logic.

---
 rtl/sensor_scan_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl: round-robin zero-run alarm scanner sharing one detector over NCH lines.
// Optional feature macro SENSOR_ALARM_CNT_EN adds a saturating accepted-alarm counter.
`timescale 1ns/1ps
module sensor_scan_ctrl #(
    parameter int NCH     = 4,
    parameter int CH_W    = 2,
    parameter int THRESH  = 8,
    parameter int DWELL   = 16,
    parameter int HOLDOFF = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  in,
    input  logic [NCH-1:0]  enable,
    input  logic            alarm_ready,
`ifdef SENSOR_ALARM_CNT_EN
    output logic [7:0]      alarm_cnt,
`endif
    output logic            alarm_valid,
    output logic [CH_W-1:0] alarm_ch,
    output logic [CH_W-1:0] cur_ch,
    output logic            busy
);

    localparam int RUN_W = $clog2(THRESH + 1);
    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int HO_W  = $clog2(HOLDOFF + 1);

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(THRESH - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SCAN,
        S_ALARM,
        S_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic              alarm_valid_q, alarm_valid_d;
    logic [CH_W-1:0]   alarm_ch_q, alarm_ch_d;
    logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
    logic              busy_q, busy_d;
    logic [CH_W-1:0]   last_ch_q, last_ch_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [HO_W-1:0]   hold_q, hold_d;
`ifdef SENSOR_ALARM_CNT_EN
    logic [7:0]        cnt_q, cnt_d;
`endif

    logic              sample;
    logic              any_en;
    logic              zero_hit;
    logic              dwell_end;
    logic              hold_end;
    logic              accept;
    logic [CH_W-1:0]   next_ch;

    assign sample    = in[cur_ch_q];
    assign any_en    = |enable;
    assign zero_hit  = !sample && (run_q == RUN_MAX);
    assign dwell_end = (dwell_q == DW_LAST);
    assign hold_end  = (hold_q == HO_LAST);
    assign accept    = (state_q == S_ALARM) && alarm_ready;

    // Grant goes to the enabled channel at the smallest circular distance past last_ch.
    always_comb begin : pick
        int best;
        int d;
        best    = NCH;
        d       = 0;
        next_ch = cur_ch_q;
        for (int i = 0; i < NCH; i++) begin
            d = (i - int'(last_ch_q) - 1 + NCH) % NCH;
            if (enable[i] && d < best) begin
                best    = d;
                next_ch = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            alarm_valid_q <= 1'b0;
            alarm_ch_q    <= '0;
            cur_ch_q      <= '0;
            busy_q        <= 1'b0;
            last_ch_q     <= CH_LAST;
            run_q         <= '0;
            dwell_q       <= '0;
            hold_q        <= '0;
`ifdef SENSOR_ALARM_CNT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            alarm_valid_q <= alarm_valid_d;
            alarm_ch_q    <= alarm_ch_d;
            cur_ch_q      <= cur_ch_d;
            busy_q        <= busy_d;
            last_ch_q     <= last_ch_d;
            run_q         <= run_d;
            dwell_q       <= dwell_d;
            hold_q        <= hold_d;
`ifdef SENSOR_ALARM_CNT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_en) state_d = S_SELECT;
            end
            S_SELECT: begin
                state_d = any_en ? S_SCAN : S_IDLE;
            end
            S_SCAN: begin
                if (zero_hit) begin
                    state_d = S_ALARM;
                end else if (!enable[cur_ch_q]) begin
                    state_d = S_SELECT;
                end else if (dwell_end) begin
                    state_d = S_SELECT;
                end
            end
            S_ALARM: begin
                if (alarm_ready) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hold_end) state_d = S_SELECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        alarm_valid_d = alarm_valid_q;
        alarm_ch_d    = alarm_ch_q;
        cur_ch_d      = cur_ch_q;
        last_ch_d     = last_ch_q;
        run_d         = run_q;
        dwell_d       = dwell_q;
        hold_d        = hold_q;
        busy_d        = (state_d != S_IDLE);
        unique case (state_q)
            S_SELECT: begin
                if (any_en) begin
                    cur_ch_d = next_ch;
                    run_d    = '0;
                    dwell_d  = '0;
                end
            end
            S_SCAN: begin
                // Saturate so a long quiet line can never wrap the run count.
                if (sample) begin
                    run_d = '0;
                end else if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_W'(1);
                end
                dwell_d = dwell_q + DW_W'(1);
                if (zero_hit) begin
                    alarm_valid_d = 1'b1;
                    alarm_ch_d    = cur_ch_q;
                end else if (!enable[cur_ch_q] || dwell_end) begin
                    last_ch_d = cur_ch_q;
                end
            end
            S_ALARM: begin
                if (alarm_ready) begin
                    alarm_valid_d = 1'b0;
                    last_ch_d     = alarm_ch_q;
                    hold_d        = '0;
                end
            end
            S_HOLD: begin
                hold_d = hold_q + HO_W'(1);
            end
            default: begin
            end
        endcase
    end

`ifdef SENSOR_ALARM_CNT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (accept && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    assign alarm_cnt = cnt_q;
`endif

    assign alarm_valid = alarm_valid_q;
    assign alarm_ch    = alarm_ch_q;
    assign cur_ch      = cur_ch_q;
    assign busy        = busy_q;

    logic unused_accept;
    assign unused_accept = accept;

endmodule
